// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared width constants, data type and counter-width helper for the pipeline slice
package pipeline_pkg;

  localparam int PIPELINE_WIDTH = 32;

  typedef logic [PIPELINE_WIDTH-1:0] pipeline_data_t;

  // Width needed to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_credit_ctr.sv
// rtl/pipeline_credit_ctr.sv - saturating up/down credit counter gating issue into the pipeline
module pipeline_credit_ctr
  import pipeline_pkg::*;
#(
  parameter int p_depth = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_issue,
  input  logic i_return,
  output logic o_credit_avail,
  output logic o_credit_err
);

  localparam int CW = cnt_width(p_depth);
  localparam logic [CW-1:0] MAX_CREDITS = CW'(p_depth);

  logic [CW-1:0] credits;
  logic          credit_err_q;

  // Issue takes a credit, return gives one back; both together cancel. Never wraps in either direction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      credits      <= MAX_CREDITS;
      credit_err_q <= 1'b0;
    end else begin
      if (i_issue && !i_return) begin
        if (credits == '0) begin
          credit_err_q <= 1'b1;
        end else begin
          credits <= credits - CW'(1);
        end
      end else if (i_return && !i_issue) begin
        if (credits != MAX_CREDITS) begin
          credits <= credits + CW'(1);
        end
      end
    end
  end

  assign o_credit_avail = (credits != '0);
  assign o_credit_err   = credit_err_q;

endmodule

// File: rtl/pipeline_drain_fifo.sv
// rtl/pipeline_drain_fifo.sv - credit-gated FIFO draining a fixed-latency pipeline; option PIPELINE_DRAIN_BYPASS_EN
module pipeline_drain_fifo
  import pipeline_pkg::*;
#(
  parameter int p_width = PIPELINE_WIDTH,
  parameter int p_depth = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_issue,
  output logic                          o_credit_avail,
  input  logic                          i_valid,
  input  logic [p_width-1:0]            i_data,
  output logic                          o_valid,
  output logic [p_width-1:0]            o_data,
  input  logic                          i_ready,
  output logic [cnt_width(p_depth)-1:0] o_count,
  output logic                          o_overflow,
  output logic                          o_credit_err
);

  localparam int CW = cnt_width(p_depth);
  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(p_depth);
  localparam logic [PW-1:0] LAST_PTR = PW'(p_depth - 1);

  logic [p_width-1:0] mem [p_depth];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [PW-1:0]      rptr_nxt;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic               valid_q;
  logic [p_width-1:0] data_q;
  logic               overflow_q;
  logic               full;
  logic               pop;
  logic               push;
  logic               bypass;
  logic               head_is_new;
  logic               credit_return;

  // Pointers wrap explicitly so depths that are not a power of two work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode and next-state for occupancy and read pointer.
  always_comb begin
    full = (count == FULL_CNT);
    pop  = valid_q && i_ready;
`ifdef PIPELINE_DRAIN_BYPASS_EN
    bypass = (count == '0) && i_valid && i_ready;
`else
    bypass = 1'b0;
`endif
    // A pop frees the slot in the same cycle, so a full FIFO can still take a word.
    push          = i_valid && !bypass && (!full || pop);
    credit_return = pop || bypass;
    // The incoming word becomes the head when nothing older survives this cycle.
    head_is_new   = push && (pop ? (count == CW'(1)) : (count == '0));
    rptr_nxt      = pop ? ptr_inc(rptr) : rptr;
    count_nxt     = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Storage array; contents are meaningless until written so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wptr] <= i_data;
    end
  end

  // Pointers, occupancy, registered head word and sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= ptr_inc(wptr);
      end
      rptr    <= rptr_nxt;
      count   <= count_nxt;
      valid_q <= (count_nxt != '0);
      if (head_is_new) begin
        data_q <= i_data;
      end else if (count_nxt != '0) begin
        data_q <= mem[rptr_nxt];
      end
      if (i_valid && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  pipeline_credit_ctr #(
    .p_depth (p_depth)
  ) u_credit (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_issue        (i_issue),
    .i_return       (credit_return),
    .o_credit_avail (o_credit_avail),
    .o_credit_err   (o_credit_err)
  );

`ifdef PIPELINE_DRAIN_BYPASS_EN
  assign o_valid = valid_q || bypass;
  assign o_data  = bypass ? i_data : data_q;
`else
  assign o_valid = valid_q;
  assign o_data  = data_q;
`endif
  assign o_count    = count;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_pipeline_drain_fifo.sv
// tb/tb_pipeline_drain_fifo.sv - directed table-driven bench for pipeline_drain_fifo
module tb_pipeline_drain_fifo;

  logic        clk = 1'b0;
  logic        rst;

  logic        issue, valid, ready;
  logic [31:0] data;
  logic        avail, ovalid, ovf, cerr;
  logic [31:0] odata;
  logic [3:0]  count;

  logic        issue5, valid5, ready5;
  logic [31:0] data5;
  logic        avail5, ovalid5, ovf5, cerr5;
  logic [31:0] odata5;
  logic [2:0]  count5;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        issue;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_count;
    logic        e_avail;
    logic        e_ovf;
    logic        e_cerr;
  } vec_t;

  vec_t vecs[19];

  always #5 clk = ~clk;

  pipeline_drain_fifo #(.p_width(32), .p_depth(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_issue(issue), .o_credit_avail(avail),
    .i_valid(valid), .i_data(data), .o_valid(ovalid), .o_data(odata),
    .i_ready(ready), .o_count(count), .o_overflow(ovf), .o_credit_err(cerr)
  );

  pipeline_drain_fifo #(.p_width(32), .p_depth(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_issue(issue5), .o_credit_avail(avail5),
    .i_valid(valid5), .i_data(data5), .o_valid(ovalid5), .o_data(odata5),
    .i_ready(ready5), .o_count(count5), .o_overflow(ovf5), .o_credit_err(cerr5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic is, input logic v, input logic r, input logic [31:0] d,
                              input logic ev, input logic [31:0] ed, input logic [3:0] ec,
                              input logic ea, input logic eo, input logic ee);
    vec_t t;
    t.issue = is; t.valid = v; t.ready = r; t.data = d;
    t.e_valid = ev; t.e_data = ed; t.e_count = ec;
    t.e_avail = ea; t.e_ovf = eo; t.e_cerr = ee;
    return t;
  endfunction

  initial begin
    // fill 8 words with downstream stalled
    for (int k = 0; k < 8; k++)
      vecs[k] = mk(1'b1, 1'b1, 1'b0, 32'(k + 1), 1'b1, 32'h1, 4'(k + 1), (k < 7), 1'b0, 1'b0);
    // full: push + pop + issue with zero credits -> no drop, no error
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 32'h9,    1'b1, 32'h2, 4'd8, 1'b0, 1'b0, 1'b0);
    // zero credits, issue without pop -> credit error
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h2, 4'd8, 1'b0, 1'b0, 1'b1);
    // full, push without pop -> dropped, overflow
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 32'hDEAD, 1'b1, 32'h2, 4'd8, 1'b0, 1'b1, 1'b1);
    // drain: 2..9 leave in order, 0xDEAD never shows
    for (int j = 0; j < 8; j++)
      vecs[11 + j] = mk(1'b0, 1'b0, 1'b1, 32'h0, (j < 7), 32'(3 + j), 4'(7 - j), 1'b1, 1'b1, 1'b1);

    issue = 0; valid = 0; ready = 0; data = 0;
    issue5 = 0; valid5 = 0; ready5 = 0; data5 = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_count",   32'(count), 32'd0);
    chk("reset_valid",   32'(ovalid), 32'd0);
    chk("reset_avail",   32'(avail), 32'd1);
    chk("reset_ovf",     32'(ovf), 32'd0);
    chk("reset_cerr",    32'(cerr), 32'd0);
    chk("reset_credits", 32'(dut.u_credit.credits), 32'd8);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_avail", 32'(avail), 32'd1);
    chk("idle_valid", 32'(ovalid), 32'd0);

    for (int i = 0; i < 19; i++) begin
      issue = vecs[i].issue; valid = vecs[i].valid;
      ready = vecs[i].ready; data = vecs[i].data;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(ovalid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("v%0d_data", i), odata, vecs[i].e_data);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_avail", i), 32'(avail), 32'(vecs[i].e_avail));
      chk($sformatf("v%0d_ovf", i),   32'(ovf),   32'(vecs[i].e_ovf));
      chk($sformatf("v%0d_cerr", i),  32'(cerr),  32'(vecs[i].e_cerr));
    end
    issue = 0; valid = 0; ready = 0;
    chk("drain_credits", 32'(dut.u_credit.credits), 32'd8);

    // reset with 3 words buffered
    for (int k = 0; k < 3; k++) begin
      issue = 1; valid = 1; data = 32'h100 + 32'(k);
      @(posedge clk); #1;
      chk($sformatf("pre_rst_count%0d", k), 32'(count), 32'(k + 1));
    end
    issue = 0; valid = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_count",   32'(count), 32'd0);
    chk("mid_rst_valid",   32'(ovalid), 32'd0);
    chk("mid_rst_credits", 32'(dut.u_credit.credits), 32'd8);
    chk("mid_rst_ovf",     32'(ovf), 32'd0);
    chk("mid_rst_cerr",    32'(cerr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // depth 5: continuous push and pop, pointers wrap four times
    for (int k = 0; k < 20; k++) begin
      issue5 = 1; valid5 = 1; ready5 = 1; data5 = 32'(k);
`ifdef PIPELINE_DRAIN_BYPASS_EN
      #1;
      chk($sformatf("w%0d_bp_valid", k), 32'(ovalid5), 32'd1);
      chk($sformatf("w%0d_bp_data", k), odata5, 32'(k));
      @(posedge clk); #1;
      chk($sformatf("w%0d_count", k), 32'(count5), 32'd0);
`else
      @(posedge clk); #1;
      chk($sformatf("w%0d_valid", k), 32'(ovalid5), 32'd1);
      chk($sformatf("w%0d_data", k), odata5, 32'(k));
      chk($sformatf("w%0d_count", k), 32'(count5), 32'd1);
`endif
    end
    issue5 = 0; valid5 = 0; ready5 = 1;
    @(posedge clk); #1;
    chk("d5_end_count",   32'(count5), 32'd0);
    chk("d5_end_valid",   32'(ovalid5), 32'd0);
    chk("d5_end_credits", 32'(dut5.u_credit.credits), 32'd5);
    chk("d5_end_ovf",     32'(ovf5), 32'd0);
    ready5 = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
